// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: architectural register file geometry and the
// packed-port slicing macro used to pick port k out of a flattened bus.
`ifndef LEGV8_SLICE
`define LEGV8_SLICE(k, w) (k)*(w) +: (w)
`endif

package legv8_pkg;
    localparam int WORD          = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int XZR_IDX       = 31;
endpackage

// File: rtl/reg_sb_cnt.sv
// Per-register pending-write counter. Saturates at all-ones and at zero;
// inc and dec together leave the count unchanged. clr has priority.
module reg_sb_cnt
    import legv8_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             nz
);

    assign full = &cnt;
    assign nz   = |cnt;

    // Count in-flight writes: +1 on issue, -1 on retire, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && nz) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// LEGv8 ID-stage register file with per-register write scoreboard.
// N combinational read ports, one write port, hardwired zero register.
// Optional macro REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding.
`ifndef LEGV8_SLICE
`define LEGV8_SLICE(k, w) (k)*(w) +: (w)
`endif

module reg_file_sb
    import legv8_pkg::*;
#(
    parameter int DATA_W   = WORD,
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = XZR_IDX,
    parameter int CNT_W    = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     flush,
    output logic                     sb_any
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] nz;
    logic [ADDR_W-1:0]   ra;

    // Indices past NUM_REGS exist only when NUM_REGS is not a power of two.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
    endfunction

    // Architectural state: zero register and out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && in_range(wr_addr) && wr_addr != ZERO_A) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // One scoreboard counter per live register; the zero register is tied off.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        if (r == ZERO_REG) begin : g_zero
            assign cnt[r]  = '0;
            assign full[r] = 1'b0;
            assign nz[r]   = 1'b0;
        end else begin : g_live
            reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .inc  (iss_valid && iss_ready && !flush && iss_addr == ADDR_W'(r)),
                .dec  (wr_en && wr_addr == ADDR_W'(r)),
                .clr  (flush),
                .cnt  (cnt[r]),
                .full (full[r]),
                .nz   (nz[r])
            );
        end
    end

    // Issue back-pressure: a retiring write in the same cycle frees a slot.
    always_comb begin
        iss_ready = 1'b1;
        if (in_range(iss_addr) && iss_addr != ZERO_A) begin
            iss_ready = !full[iss_addr] ||
                        (wr_en && wr_addr == iss_addr && nz[iss_addr]);
        end
    end

    // Read ports: data and busy flag per port, zero for XZR and bad indices.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[`LEGV8_SLICE(k, ADDR_W)];
            if (in_range(ra) && ra != ZERO_A) begin
                rd_data[`LEGV8_SLICE(k, DATA_W)] = mem[ra];
                rd_busy[k] = cnt[ra] != '0;
`ifdef REG_FILE_BYPASS_EN
                // Forward the retiring value; busy reflects the post-retire count.
                if (wr_en && wr_addr == ra) begin
                    rd_data[`LEGV8_SLICE(k, DATA_W)] = wr_data;
                    rd_busy[k] = cnt[ra] > CNT_W'(1);
                end
`endif
            end
        end
    end

    assign sb_any = |nz;

endmodule
